// File: rtl/butterfly_r2_pipe.sv
// Radix-2 complex butterfly (DIT or DIF per sample) with run-time twiddle, round-half-up, optional /2 and saturation.
// Latency: 3 en-high cycles, one sample pair per cycle.
// Backpressure: none; en=0 freezes every stage and the outputs, only ovf_sticky still honours clr_ovf.
module butterfly_r2_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16,
    parameter int TW_FRAC    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         valid_in,
    input  logic                         dif,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] real_in0,
    input  logic signed [DATA_WIDTH-1:0] imag_in0,
    input  logic signed [DATA_WIDTH-1:0] real_in1,
    input  logic signed [DATA_WIDTH-1:0] imag_in1,
    input  logic signed [TW_WIDTH-1:0]   tw_real,
    input  logic signed [TW_WIDTH-1:0]   tw_imag,
    input  logic                         clr_ovf,
    output logic signed [DATA_WIDTH-1:0] real_out0,
    output logic signed [DATA_WIDTH-1:0] imag_out0,
    output logic signed [DATA_WIDTH-1:0] real_out1,
    output logic signed [DATA_WIDTH-1:0] imag_out1,
    output logic                         valid_out,
    output logic                         ovf_out,
    output logic                         ovf_sticky
);

    localparam int XW = DATA_WIDTH + 1;
    localparam int PW = DATA_WIDTH + TW_WIDTH + 2;
    localparam int RW = PW - TW_FRAC;
    // Two guard bits over the rounded product cover x0 +/- t and the +1 of the halving step.
    localparam int SW = RW + 2;

    localparam logic signed [PW-1:0] RND_HALF = {{(PW-1){1'b0}}, 1'b1} << (TW_FRAC - 1);
    localparam logic signed [SW-1:0] ONE      = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] MAXV     = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV     = ~MAXV;

    // Returns {overflow, value}: optional round-half-up halving, then clamp to the output range.
    function automatic logic [DATA_WIDTH:0] finish(input logic signed [SW-1:0] v,
                                                   input logic                 halve);
        logic signed [SW-1:0] s;
        s = halve ? ((v + ONE) >>> 1) : v;
        if (s > MAXV) begin
            return {1'b1, DATA_WIDTH'(MAXV)};
        end else if (s < MINV) begin
            return {1'b1, DATA_WIDTH'(MINV)};
        end else begin
            return {1'b0, DATA_WIDTH'(s)};
        end
    endfunction

    // Stage 1: input capture
    logic signed [DATA_WIDTH-1:0] s1_x0r, s1_x0i, s1_x1r, s1_x1i;
    logic signed [TW_WIDTH-1:0]   s1_wr, s1_wi;
    logic                         s1_dif, s1_scale, s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x0r   <= '0;
            s1_x0i   <= '0;
            s1_x1r   <= '0;
            s1_x1i   <= '0;
            s1_wr    <= '0;
            s1_wi    <= '0;
            s1_dif   <= 1'b0;
            s1_scale <= 1'b0;
            s1_vld   <= 1'b0;
        end else if (en) begin
            s1_x0r   <= real_in0;
            s1_x0i   <= imag_in0;
            s1_x1r   <= real_in1;
            s1_x1i   <= imag_in1;
            s1_wr    <= tw_real;
            s1_wi    <= tw_imag;
            s1_dif   <= dif;
            s1_scale <= scale;
            s1_vld   <= valid_in;
        end
    end

    // Stage 2: operand select and full-precision complex multiply
    logic signed [XW-1:0] x0r_e, x0i_e, x1r_e, x1i_e;
    logic signed [XW-1:0] op_r, op_i, sum_r, sum_i;
    logic signed [PW-1:0] prod_r, prod_i;

    always_comb begin
        x0r_e  = XW'(s1_x0r);
        x0i_e  = XW'(s1_x0i);
        x1r_e  = XW'(s1_x1r);
        x1i_e  = XW'(s1_x1i);
        sum_r  = x0r_e + x1r_e;
        sum_i  = x0i_e + x1i_e;
        op_r   = s1_dif ? (x0r_e - x1r_e) : x1r_e;
        op_i   = s1_dif ? (x0i_e - x1i_e) : x1i_e;
        prod_r = PW'(op_r) * PW'(s1_wr) - PW'(op_i) * PW'(s1_wi);
        prod_i = PW'(op_r) * PW'(s1_wi) + PW'(op_i) * PW'(s1_wr);
    end

    logic signed [PW-1:0] s2_pr, s2_pi;
    logic signed [XW-1:0] s2_x0r, s2_x0i, s2_sr, s2_si;
    logic                 s2_dif, s2_scale, s2_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_pr    <= '0;
            s2_pi    <= '0;
            s2_x0r   <= '0;
            s2_x0i   <= '0;
            s2_sr    <= '0;
            s2_si    <= '0;
            s2_dif   <= 1'b0;
            s2_scale <= 1'b0;
            s2_vld   <= 1'b0;
        end else if (en) begin
            s2_pr    <= prod_r;
            s2_pi    <= prod_i;
            s2_x0r   <= x0r_e;
            s2_x0i   <= x0i_e;
            s2_sr    <= sum_r;
            s2_si    <= sum_i;
            s2_dif   <= s1_dif;
            s2_scale <= s1_scale;
            s2_vld   <= s1_vld;
        end
    end

    // Stage 3: round, add/sub, scale, saturate
    logic signed [RW-1:0]   t_r, t_i;
    logic signed [SW-1:0]   y0r, y0i, y1r, y1i;
    logic [DATA_WIDTH:0]    q0r, q0i, q1r, q1i;
    logic                   ovf_any;

    always_comb begin
        t_r = RW'((s2_pr + RND_HALF) >>> TW_FRAC);
        t_i = RW'((s2_pi + RND_HALF) >>> TW_FRAC);
        if (s2_dif) begin
            y0r = SW'(s2_sr);
            y0i = SW'(s2_si);
            y1r = SW'(t_r);
            y1i = SW'(t_i);
        end else begin
            y0r = SW'(s2_x0r) + SW'(t_r);
            y0i = SW'(s2_x0i) + SW'(t_i);
            y1r = SW'(s2_x0r) - SW'(t_r);
            y1i = SW'(s2_x0i) - SW'(t_i);
        end
        q0r     = finish(y0r, s2_scale);
        q0i     = finish(y0i, s2_scale);
        q1r     = finish(y1r, s2_scale);
        q1i     = finish(y1i, s2_scale);
        ovf_any = q0r[DATA_WIDTH] | q0i[DATA_WIDTH] | q1r[DATA_WIDTH] | q1i[DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            real_out0 <= '0;
            imag_out0 <= '0;
            real_out1 <= '0;
            imag_out1 <= '0;
            valid_out <= 1'b0;
            ovf_out   <= 1'b0;
        end else if (en) begin
            real_out0 <= q0r[DATA_WIDTH-1:0];
            imag_out0 <= q0i[DATA_WIDTH-1:0];
            real_out1 <= q1r[DATA_WIDTH-1:0];
            imag_out1 <= q1i[DATA_WIDTH-1:0];
            valid_out <= s2_vld;
            ovf_out   <= s2_vld & ovf_any;
        end
    end

    // A set on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (en && s2_vld && ovf_any) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Scoreboard bench for butterfly_r2_pipe: directed vectors plus randomized stream against an integer reference model.
module tb_butterfly_r2_pipe;

    localparam int DW = 16;
    localparam int TW = 16;
    localparam int TF = 15;
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, valid_in, dif, scale, clr_ovf;
    logic signed [DW-1:0] real_in0, imag_in0, real_in1, imag_in1;
    logic signed [TW-1:0] tw_real, tw_imag;
    logic signed [DW-1:0] real_out0, imag_out0, real_out1, imag_out1;
    logic valid_out, ovf_out, ovf_sticky;

    butterfly_r2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW), .TW_FRAC(TF)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in), .dif(dif), .scale(scale),
        .real_in0(real_in0), .imag_in0(imag_in0), .real_in1(real_in1), .imag_in1(imag_in1),
        .tw_real(tw_real), .tw_imag(tw_imag), .clr_ovf(clr_ovf),
        .real_out0(real_out0), .imag_out0(imag_out0), .real_out1(real_out1), .imag_out1(imag_out1),
        .valid_out(valid_out), .ovf_out(ovf_out), .ovf_sticky(ovf_sticky)
    );

    typedef struct {
        longint y0r, y0i, y1r, y1i;
        bit     ovf;
        longint due;
    } exp_t;

    exp_t   sbq[$];
    longint adv = 0;
    int     checks = 0;
    int     errors = 0;
    bit     sticky_m = 1'b0;
    bit     last_vld = 1'b0;
    exp_t   last_exp;

    task automatic check(input string nm, input logic signed [63:0] act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the mathematical definition.
    function automatic longint rnd(input longint v);
        return (v + (64'sd1 <<< (TF - 1))) >>> TF;
    endfunction

    function automatic exp_t model(input longint a0r, a0i, a1r, a1i, wr, wi, input bit d, sc);
        exp_t   e;
        longint mr, mi, pr, pi;
        longint v[4];
        mr = d ? a0r - a1r : a1r;
        mi = d ? a0i - a1i : a1i;
        pr = rnd(mr * wr - mi * wi);
        pi = rnd(mr * wi + mi * wr);
        if (d) v = '{a0r + a1r, a0i + a1i, pr, pi};
        else   v = '{a0r + pr, a0i + pi, a0r - pr, a0i - pi};
        e.ovf = 1'b0;
        foreach (v[k]) begin
            if (sc) v[k] = (v[k] + 1) >>> 1;
            if (v[k] > MAXV) begin v[k] = MAXV; e.ovf = 1'b1; end
            if (v[k] < MINV) begin v[k] = MINV; e.ovf = 1'b1; end
        end
        e.y0r = v[0]; e.y0i = v[1]; e.y1r = v[2]; e.y1i = v[3];
        e.due = 0;
        return e;
    endfunction

    task automatic apply(input longint a0r, a0i, a1r, a1i, wr, wi, input bit d, sc);
        real_in0 = DW'(a0r); imag_in0 = DW'(a0i);
        real_in1 = DW'(a1r); imag_in1 = DW'(a1i);
        tw_real  = TW'(wr);  tw_imag  = TW'(wi);
        dif = d; scale = sc;
    endtask

    task automatic send(input longint a0r, a0i, a1r, a1i, wr, wi, input bit d, sc);
        exp_t e;
        apply(a0r, a0i, a1r, a1i, wr, wi, d, sc);
        en = 1'b1; valid_in = 1'b1;
        e = model(a0r, a0i, a1r, a1i, wr, wi, d, sc);
        e.due = adv + 3;
        sbq.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send_lit(input longint a0r, a0i, a1r, a1i, wr, wi, input bit d, sc,
                            input longint y0r, y0i, y1r, y1i, input bit ov);
        exp_t e;
        apply(a0r, a0i, a1r, a1i, wr, wi, d, sc);
        en = 1'b1; valid_in = 1'b1;
        e.y0r = y0r; e.y0i = y0i; e.y1r = y1r; e.y1i = y1i; e.ovf = ov;
        e.due = adv + 3;
        sbq.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b1; valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    function automatic longint r16();
        return longint'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic longint rsmall();
        return longint'($urandom_range(0, 4000)) - 2000;
    endfunction

    // Monitor: one decision per clock edge, sampled 1 time unit after it.
    initial begin : monitor
        bit   e_s, c_s, r_s, set;
        exp_t x;
        forever begin
            @(posedge clk);
            e_s = en; c_s = clr_ovf; r_s = rst_n;
            #1;
            if (!r_s) begin
                sticky_m = 1'b0;
                last_vld = 1'b0;
            end else begin
                set = 1'b0;
                if (e_s) begin
                    adv++;
                    while (sbq.size() > 0 && sbq[0].due < adv) begin
                        x = sbq.pop_front();
                        check("missed output due", adv, x.due);
                    end
                    if (sbq.size() > 0 && sbq[0].due == adv) begin
                        x = sbq.pop_front();
                        check("valid_out", valid_out, 1);
                        check("y0 re", real_out0, x.y0r);
                        check("y0 im", imag_out0, x.y0i);
                        check("y1 re", real_out1, x.y1r);
                        check("y1 im", imag_out1, x.y1i);
                        check("ovf_out", ovf_out, longint'(x.ovf));
                        set = x.ovf;
                        last_exp = x;
                        last_vld = 1'b1;
                    end else begin
                        check("valid_out idle", valid_out, 0);
                        check("ovf_out idle", ovf_out, 0);
                        last_vld = 1'b0;
                    end
                end else begin
                    check("stall valid_out", valid_out, longint'(last_vld));
                    if (last_vld) begin
                        check("stall y0 re", real_out0, last_exp.y0r);
                        check("stall y0 im", imag_out0, last_exp.y0i);
                        check("stall y1 re", real_out1, last_exp.y1r);
                        check("stall y1 im", imag_out1, last_exp.y1i);
                        check("stall ovf_out", ovf_out, longint'(last_exp.ovf));
                    end else begin
                        check("stall ovf_out idle", ovf_out, 0);
                    end
                end
                sticky_m = set ? 1'b1 : (c_s ? 1'b0 : sticky_m);
                check("ovf_sticky", ovf_sticky, longint'(sticky_m));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached with %0d results outstanding", sbq.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        longint a0r, a0i, a1r, a1i, wr, wi;
        bit     ve, vv, d, sc;
        exp_t   e;
        int     waited;

        rst_n = 1'b0; en = 1'b0; valid_in = 1'b0; clr_ovf = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        #2;
        check("reset real_out0", real_out0, 0);
        check("reset imag_out1", imag_out1, 0);
        check("reset valid_out", valid_out, 0);
        check("reset ovf_out", ovf_out, 0);
        check("reset ovf_sticky", ovf_sticky, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed vectors with hand-derived results
        send_lit(1000, 2000, 300, -400, 0, -32768, 1'b0, 1'b0, 600, 1700, 1400, 2300, 1'b0);
        idle(3);
        send_lit(30000, -30000, 10000, -10000, -32768, 0, 1'b0, 1'b0, 20000, -20000, 32767, -32768, 1'b1);
        send_lit(30000, -30000, 10000, -10000, -32768, 0, 1'b0, 1'b1, 10000, -10000, 20000, -20000, 1'b0);
        send_lit(100, 50, 20, 10, 0, -32768, 1'b1, 1'b0, 120, 60, 40, -80, 1'b0);
        send_lit(0, 0, 1, 0, 16384, 0, 1'b0, 1'b0, 1, 0, -1, 0, 1'b0);
        send_lit(0, 0, -1, 0, 16384, 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        idle(4);
        check("sticky after saturation", ovf_sticky, 1);

        // Back-to-back stream with alternating modes, then a mid-stream stall
        for (int i = 0; i < 5; i++)
            send(rsmall(), rsmall(), r16(), r16(), r16(), r16(), i[0], ~i[0]);
        for (int i = 0; i < 3; i++)
            send(r16(), r16(), r16(), r16(), r16(), r16(), i[0], i[1]);
        en = 1'b0; valid_in = 1'b1;
        apply(123, 456, 789, 1011, 1213, 1415, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++)
            send(r16(), r16(), rsmall(), rsmall(), r16(), r16(), i[0], 1'b0);
        idle(4);

        // Reset with two samples in flight
        send(r16(), r16(), r16(), r16(), r16(), r16(), 1'b0, 1'b0);
        send(r16(), r16(), r16(), r16(), r16(), r16(), 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        sbq.delete();
        check("mid reset valid_out", valid_out, 0);
        check("mid reset real_out0", real_out0, 0);
        check("mid reset imag_out0", imag_out0, 0);
        check("mid reset real_out1", real_out1, 0);
        check("mid reset ovf_sticky", ovf_sticky, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        send(rsmall(), rsmall(), rsmall(), rsmall(), r16(), r16(), 1'b0, 1'b0);
        idle(4);

        // Sticky clear, then clear coincident with a fresh overflow
        send(30000, 30000, 30000, 30000, -32768, 0, 1'b0, 1'b0);
        idle(4);
        check("sticky before clear", ovf_sticky, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("sticky after clear", ovf_sticky, 0);
        send(30000, 30000, 30000, 30000, -32768, 0, 1'b0, 1'b0);
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("sticky set beats clear", ovf_sticky, 1);
        idle(3);

        // Randomized stream with random stalls, invalid gaps and clears
        for (int i = 0; i < 400; i++) begin
            ve = ($urandom_range(0, 9) < 8);
            vv = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1);
            sc = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0) begin
                a0r = r16(); a0i = r16(); a1r = r16(); a1i = r16();
            end else begin
                a0r = rsmall(); a0i = rsmall(); a1r = rsmall(); a1i = rsmall();
            end
            wr = ($urandom_range(0, 15) == 0) ? -32768 : r16();
            wi = r16();
            apply(a0r, a0i, a1r, a1i, wr, wi, d, sc);
            en = ve; valid_in = vv;
            clr_ovf = ($urandom_range(0, 19) == 0);
            if (ve && vv) begin
                e = model(a0r, a0i, a1r, a1i, wr, wi, d, sc);
                e.due = adv + 3;
                sbq.push_back(e);
            end
            @(negedge clk);
        end
        clr_ovf = 1'b0;

        waited = 0;
        en = 1'b1; valid_in = 1'b0;
        while (sbq.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard drained", sbq.size(), 0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
